// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM single-port RAM arbiter.
// FSM encodings, grant ids and default widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } arb_gnt_t;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int TO_CYCLES_DEF  = 255;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating up-counter with increment/clear and an at-max flag.
// Ports: i_clk, i_rst (async high), i_inc, i_clr (wins), o_at_max.
module mem_port_arbiter_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] r_cnt;

    assign o_at_max = (r_cnt == W'(MAX));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one single-port RAM.
// Ports: i_clk/i_rst; IF req/addr -> rdata/ack; MEM req/we/addr/wdata ->
// rdata/ack; RAM en/we/addr/wdata <- rdata/ready; if/mem stall; timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TO_CYCLES  = TO_CYCLES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_ack,
    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic              o_mem_ack,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    input  logic              i_ram_ready,
    output logic              o_if_stall,
    output logic              o_mem_stall,
    output logic              o_timeout
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_gnt_t          r_gnt;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_ack;
    logic              r_mem_ack;
    logic              r_timeout;

    logic              w_start;
    logic              w_done;
    logic              w_abort;
    logic              w_gnt_mem;
    logic              w_starve_max;
    logic              w_wd_max;
    logic [DATA_W-1:0] w_rdata;

    // MEM is the older instruction and wins, unless IF has been
    // passed over STARVE_MAX times in a row.
    assign w_gnt_mem = i_mem_req & ~(i_if_req & w_starve_max);
    assign w_rdata   = w_abort ? '0 : i_ram_rdata;

    mem_port_arbiter_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_inc    (w_start & w_gnt_mem & i_if_req),
        .i_clr    ((r_state == ST_IDLE) & (~i_if_req | (w_start & ~w_gnt_mem))),
        .o_at_max (w_starve_max)
    );

    // Watchdog: counts only while a RAM access is outstanding.
    mem_port_arbiter_starve_ctr #(
        .MAX (TO_CYCLES)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_inc    (r_state == ST_BUSY),
        .i_clr    (r_state != ST_BUSY),
        .o_at_max (w_wd_max)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_if_req || i_mem_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_ram_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_ACK;
                end else if (w_wd_max) begin
                    w_done      = 1'b1;
                    w_abort     = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gnt       <= GNT_IF;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_ram_en  <= 1'b0;
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            if (w_start) begin
                r_ram_en <= 1'b1;
                if (w_gnt_mem) begin
                    r_gnt       <= GNT_MEM;
                    r_ram_we    <= i_mem_we;
                    r_ram_addr  <= i_mem_addr;
                    r_ram_wdata <= i_mem_wdata;
                end else begin
                    r_gnt       <= GNT_IF;
                    r_ram_we    <= 1'b0;
                    r_ram_addr  <= i_if_addr;
                    r_ram_wdata <= '0;
                end
            end
            if (w_done) begin
                if (r_gnt == GNT_MEM) begin
                    r_mem_ack <= 1'b1;
                    // A store leaves the last load result in place.
                    if (!r_ram_we) begin
                        r_mem_rdata <= w_rdata;
                    end
                end else begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= w_rdata;
                end
                if (w_abort) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_mem_rdata = r_mem_rdata;
    assign o_if_ack    = r_if_ack;
    assign o_mem_ack   = r_mem_ack;
    assign o_timeout   = r_timeout;
    assign o_if_stall  = i_if_req & ~r_if_ack;
    assign o_mem_stall = i_mem_req & ~r_mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_MAX=4, TO_CYCLES=8).
// RAM answers one cycle after ram_en unless auto_resp is cleared.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] resp_data = '0;
    logic        ram_ready;
    logic        if_stall;
    logic        mem_stall;
    logic        timeout;

    logic        auto_resp = 1'b0;
    logic        stray = 1'b0;
    logic        en_seen = 1'b0;
    logic        rdy_auto = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    logic [31:0] exp_addr [6];
    logic        exp_mem  [6];

    always #5 clk = ~clk;

    assign ram_ready = rdy_auto | stray;

    always @(negedge clk) en_seen = ram_en & auto_resp;
    always @(posedge clk) begin
        #1;
        rdy_auto = en_seen;
    end

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4),
        .TO_CYCLES  (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_rdata  (if_rdata),
        .o_if_ack    (if_ack),
        .i_mem_req   (mem_req),
        .i_mem_we    (mem_we),
        .i_mem_addr  (mem_addr),
        .i_mem_wdata (mem_wdata),
        .o_mem_rdata (mem_rdata),
        .o_mem_ack   (mem_ack),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (resp_data),
        .i_ram_ready (ram_ready),
        .o_if_stall  (if_stall),
        .o_mem_stall (mem_stall),
        .o_timeout   (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_addr = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h48, 32'h300};
        exp_mem  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // reset state
        tick();
        tick();
        chk("rst_en", 32'(ram_en), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_ifack", 32'(if_ack), 32'd0);
        chk("rst_memack", 32'(mem_ack), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        chk("rst_addr", ram_addr, 32'd0);
        chk("rst_ifrd", if_rdata, 32'd0);
        chk("rst_memrd", mem_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // reset while BUSY
        if_req = 1'b1;
        if_addr = 32'h80;
        tick();
        chk("t1_en", 32'(ram_en), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("t1_rst_en", 32'(ram_en), 32'd0);
        tick();
        chk("t1_rst_ack", 32'(if_ack), 32'd0);
        chk("t1_rst_addr", ram_addr, 32'd0);
        rst = 1'b0;
        if_addr = 32'h84;
        auto_resp = 1'b1;
        resp_data = 32'hA5A50001;
        tick();
        chk("t1_new_en", 32'(ram_en), 32'd1);
        chk("t1_new_addr", ram_addr, 32'h84);
        tick();
        tick();
        chk("t1_new_ack", 32'(if_ack), 32'd1);
        chk("t1_new_rd", if_rdata, 32'hA5A50001);
        if_req = 1'b0;
        tick();

        // single fetch, best latency
        if_req = 1'b1;
        if_addr = 32'h40;
        resp_data = 32'hDEADBEEF;
        tick();
        chk("t2_en", 32'(ram_en), 32'd1);
        chk("t2_we", 32'(ram_we), 32'd0);
        chk("t2_addr", ram_addr, 32'h40);
        chk("t2_stall_hi", 32'(if_stall), 32'd1);
        tick();
        chk("t2_en_drop", 32'(ram_en), 32'd0);
        chk("t2_noack", 32'(if_ack), 32'd0);
        tick();
        chk("t2_ack", 32'(if_ack), 32'd1);
        chk("t2_rd", if_rdata, 32'hDEADBEEF);
        chk("t2_stall_lo", 32'(if_stall), 32'd0);
        if_req = 1'b0;
        tick();
        chk("t2_ack_pulse", 32'(if_ack), 32'd0);

        // simultaneous: MEM first, then IF
        if_req = 1'b1;
        if_addr = 32'h44;
        mem_req = 1'b1;
        mem_addr = 32'h100;
        resp_data = 32'h11112222;
        tick();
        chk("t3_addr_mem", ram_addr, 32'h100);
        chk("t3_ifstall1", 32'(if_stall), 32'd1);
        tick();
        tick();
        chk("t3_memack", 32'(mem_ack), 32'd1);
        chk("t3_memrd", mem_rdata, 32'h11112222);
        chk("t3_ifack0", 32'(if_ack), 32'd0);
        chk("t3_ifstall2", 32'(if_stall), 32'd1);
        chk("t3_memstall", 32'(mem_stall), 32'd0);
        mem_req = 1'b0;
        resp_data = 32'h33334444;
        tick();
        chk("t3_ifstall3", 32'(if_stall), 32'd1);
        tick();
        chk("t3_en_if", 32'(ram_en), 32'd1);
        chk("t3_addr_if", ram_addr, 32'h44);
        tick();
        tick();
        chk("t3_ifack", 32'(if_ack), 32'd1);
        chk("t3_ifrd", if_rdata, 32'h33334444);
        if_req = 1'b0;
        tick();

        // starvation limit: MEM x4 then IF
        resp_data = 32'h5555AAAA;
        if_req = 1'b1;
        if_addr = 32'h48;
        mem_req = 1'b1;
        mem_addr = 32'h300;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("t4_en%0d", k), 32'(ram_en), 32'd1);
            chk($sformatf("t4_addr%0d", k), ram_addr, exp_addr[k]);
            tick();
            tick();
            chk($sformatf("t4_memack%0d", k), 32'(mem_ack),
                32'(exp_mem[k]));
            chk($sformatf("t4_ifack%0d", k), 32'(if_ack),
                32'(!exp_mem[k]));
            tick();
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        tick();

        // store; payload changes while BUSY are ignored
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'h200;
        mem_wdata = 32'h12345678;
        resp_data = 32'hFFFFFFFF;
        tick();
        chk("t5_en", 32'(ram_en), 32'd1);
        chk("t5_we", 32'(ram_we), 32'd1);
        chk("t5_addr", ram_addr, 32'h200);
        chk("t5_wdata", ram_wdata, 32'h12345678);
        mem_addr = 32'h204;
        mem_wdata = 32'h0;
        tick();
        chk("t5_addr_hold", ram_addr, 32'h200);
        chk("t5_wdata_hold", ram_wdata, 32'h12345678);
        tick();
        chk("t5_ack", 32'(mem_ack), 32'd1);
        chk("t5_rd_keep", mem_rdata, 32'h5555AAAA);
        mem_req = 1'b0;
        mem_we = 1'b0;
        tick();
        chk("t5_ack_pulse", 32'(mem_ack), 32'd0);

        // requester drops req mid-transaction
        if_req = 1'b1;
        if_addr = 32'h4C;
        resp_data = 32'h0BADF00D;
        tick();
        chk("td_en", 32'(ram_en), 32'd1);
        if_req = 1'b0;
        tick();
        tick();
        chk("td_ack", 32'(if_ack), 32'd1);
        chk("td_rd", if_rdata, 32'h0BADF00D);
        chk("td_stall", 32'(if_stall), 32'd0);
        tick();

        // watchdog
        auto_resp = 1'b0;
        resp_data = 32'h99999999;
        if_req = 1'b1;
        if_addr = 32'h50;
        tick();
        chk("t6_en", 32'(ram_en), 32'd1);
        repeat (8) tick();
        chk("t6_noack", 32'(if_ack), 32'd0);
        chk("t6_to0", 32'(timeout), 32'd0);
        tick();
        chk("t6_ack", 32'(if_ack), 32'd1);
        chk("t6_rd0", if_rdata, 32'd0);
        chk("t6_to1", 32'(timeout), 32'd1);
        if_req = 1'b0;
        tick();

        // ram_ready while IDLE is ignored
        stray = 1'b1;
        resp_data = 32'h77777777;
        tick();
        stray = 1'b0;
        chk("ts_en", 32'(ram_en), 32'd0);
        tick();
        chk("ts_ifack", 32'(if_ack), 32'd0);
        chk("ts_memack", 32'(mem_ack), 32'd0);
        chk("ts_rd", if_rdata, 32'd0);

        // timeout stays set until reset
        auto_resp = 1'b1;
        resp_data = 32'h00000001;
        if_req = 1'b1;
        if_addr = 32'h54;
        tick();
        tick();
        tick();
        chk("t6_sticky_ack", 32'(if_ack), 32'd1);
        chk("t6_sticky_to", 32'(timeout), 32'd1);
        if_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t6_to_rst", 32'(timeout), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
